// File: rtl/mlp_train_scheduler.sv
// Training sequencer for the MLP layer array: walks samples/epochs and strobes load, settle, update.
// Optional epoch-loss accumulator is built only when MLP_TRAIN_SCHED_LOSS_EN is defined.
module mlp_train_scheduler #(
  parameter int ADDR_W        = 4,
  parameter int EPOCH_W       = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               init_weights,
  input  logic [ADDR_W:0]    num_samples,
  input  logic [EPOCH_W-1:0] num_epochs,
  input  logic               abort,
  input  real                sample_sq_error,
  output logic [ADDR_W-1:0]  sample_addr,
  output logic               load_sample,
  output logic               training,
  output logic               layer_rst,
  output logic               busy,
  output logic               done,
  output logic [EPOCH_W-1:0] epoch_count,
  output real                epoch_loss,
  output logic               epoch_loss_valid,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_LOAD, S_SETTLE, S_UPDATE, S_NEXT, S_DONE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic [3:0]         settle_q, settle_d;
  logic [ADDR_W:0]    ns_q, ns_d;
  logic [EPOCH_W-1:0] ne_q, ne_d;

  logic [ADDR_W:0] idx_inc_ext;
  logic            more_samples;
  logic            last_epoch;
  logic            abort_hit;

  assign idx_inc_ext  = {1'b0, idx_q} + (ADDR_W+1)'(1);
  assign more_samples = idx_inc_ext < ns_q;
  assign last_epoch   = (epoch_q == ne_q - EPOCH_W'(1));
  assign abort_hit    = abort && (state_q != S_IDLE);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    epoch_d  = epoch_q;
    settle_d = settle_q;
    ns_d     = ns_q;
    ne_d     = ne_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ns_d     = num_samples;
          ne_d     = num_epochs;
          idx_d    = '0;
          epoch_d  = '0;
          settle_d = '0;
          if ((num_samples == '0) || (num_epochs == '0)) state_d = S_DONE;
          else if (init_weights)                         state_d = S_INIT;
          else                                           state_d = S_LOAD;
        end
      end
      S_INIT:   state_d = S_LOAD;
      S_LOAD:   state_d = S_SETTLE;
      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = S_UPDATE;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      S_UPDATE: state_d = S_NEXT;
      S_NEXT: begin
        if (more_samples) begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = S_LOAD;
        end else begin
          idx_d = '0;
          if (last_epoch) begin
            state_d = S_DONE;
          end else begin
            epoch_d = epoch_q + EPOCH_W'(1);
            state_d = S_LOAD;
          end
        end
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // Abort overrides every transition outside IDLE; the counters simply stop.
    if (abort_hit) begin
      state_d  = S_IDLE;
      settle_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      epoch_q  <= '0;
      settle_q <= '0;
      ns_q     <= '0;
      ne_q     <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      epoch_q  <= epoch_d;
      settle_q <= settle_d;
      ns_q     <= ns_d;
      ne_q     <= ne_d;
    end
  end

  // Update-side strobes are masked by abort in the same cycle so no layer changes after an abort.
  assign load_sample = (state_q == S_LOAD);
  assign training    = (state_q == S_UPDATE) && !abort;
  assign layer_rst   = (state_q == S_INIT) && !abort;
  assign done        = (state_q == S_DONE) && !abort;
  assign busy        = (state_q != S_IDLE);
  assign sample_addr = idx_q;
  assign epoch_count = epoch_q;
  assign state_dbg   = state_q;

`ifdef MLP_TRAIN_SCHED_LOSS_EN
  real  acc_q, acc_d, loss_q, loss_d;
  logic loss_valid_q, loss_valid_d;

  always_comb begin
    acc_d        = acc_q;
    loss_d       = loss_q;
    loss_valid_d = 1'b0;
    if ((state_q == S_IDLE) && start) begin
      acc_d = 0.0;
    end else if (abort_hit) begin
      acc_d = 0.0;
    end else if (state_q == S_UPDATE) begin
      acc_d = acc_q + sample_sq_error;
    end else if ((state_q == S_NEXT) && !more_samples) begin
      loss_d       = acc_q / real'(ns_q);
      loss_valid_d = 1'b1;
      acc_d        = 0.0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q        <= 0.0;
      loss_q       <= 0.0;
      loss_valid_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      loss_q       <= loss_d;
      loss_valid_q <= loss_valid_d;
    end
  end

  assign epoch_loss       = loss_q;
  assign epoch_loss_valid = loss_valid_q;
`else
  logic sq_error_unused;
  assign sq_error_unused  = (sample_sq_error != 0.0);
  assign epoch_loss       = 0.0;
  assign epoch_loss_valid = 1'b0;
`endif

endmodule

// File: tb/tb_mlp_train_scheduler.sv
// Bench for mlp_train_scheduler: table-driven runs, random runs against a sample-order model,
// plus hand-written abort and mid-run reset sequences.
module tb_mlp_train_scheduler;
  localparam int ADDR_W  = 4;
  localparam int EPOCH_W = 16;
  localparam int SETTLE  = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic               init_weights = 1'b0;
  logic [ADDR_W:0]    num_samples = '0;
  logic [EPOCH_W-1:0] num_epochs = '0;
  logic               abort = 1'b0;
  real                sample_sq_error = 0.0;
  logic [ADDR_W-1:0]  sample_addr;
  logic               load_sample;
  logic               training;
  logic               layer_rst;
  logic               busy;
  logic               done;
  logic [EPOCH_W-1:0] epoch_count;
  real                epoch_loss;
  logic               epoch_loss_valid;
  logic [2:0]         state_dbg;

  mlp_train_scheduler #(
    .ADDR_W(ADDR_W), .EPOCH_W(EPOCH_W), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .init_weights(init_weights),
    .num_samples(num_samples), .num_epochs(num_epochs), .abort(abort),
    .sample_sq_error(sample_sq_error), .sample_addr(sample_addr),
    .load_sample(load_sample), .training(training), .layer_rst(layer_rst),
    .busy(busy), .done(done), .epoch_count(epoch_count), .epoch_loss(epoch_loss),
    .epoch_loss_valid(epoch_loss_valid), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [ADDR_W-1:0] exp_q[$];
  int last_len;
  int last_trains;

  typedef struct {
    bit init;
    int ns;
    int ne;
    int exp_len;
    int exp_train;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: sample order is every index of every epoch; per-sample error is 0.5 + index.
  task automatic do_run(input bit init, input int ns, input int ne, input int abort_upd);
    int  total, exp_len, cyc, trains, loads, rsts, last_load, first_load, first_rst, loss_pulses;
    real exp_loss;
    bit  seen_done, aborted;
    total = ns * ne;
    exp_len = (total == 0) ? 1 : (init ? 1 : 0) + total * (SETTLE + 3) + 1;
    exp_q.delete();
    for (int e = 0; e < ne; e++)
      for (int s = 0; s < ns; s++) exp_q.push_back(ADDR_W'(s));
    exp_loss = 0.0;
    for (int s = 0; s < ns; s++) exp_loss += 0.5 + real'(s);
    if (ns > 0) exp_loss = exp_loss / real'(ns);
    cyc = 0; trains = 0; loads = 0; rsts = 0; last_load = -100;
    first_load = -1; first_rst = -1; loss_pulses = 0; seen_done = 0; aborted = 0;

    start = 1'b1; init_weights = init;
    num_samples = (ADDR_W+1)'(ns); num_epochs = EPOCH_W'(ne);
    @(negedge clk);
    start = 1'b0;
    num_samples = (ADDR_W+1)'($urandom_range(0, 16));
    num_epochs  = EPOCH_W'($urandom_range(0, 9));
    check("busy_rise", busy, 1);

    for (int k = 0; k < 3000 && !seen_done && !aborted; k++) begin
      cyc++;
      if (abort_upd > 0 && loads == abort_upd && cyc == last_load + SETTLE + 1) begin
        abort = 1'b1;
        #1;
        check("abort_training_gated", training, 0);
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle_busy", busy, 0);
        check("abort_no_done", done, 0);
        aborted = 1;
      end else begin
        if (busy !== 1'b1) begin
          check("busy_hold", busy, 1);
          break;
        end
        if (load_sample) begin
          loads++;
          if (exp_q.size() == 0) check("load_count", loads, total);
          else check("sample_addr", sample_addr, exp_q.pop_front());
          last_load = cyc;
          if (first_load < 0) first_load = cyc;
          sample_sq_error = 0.5 + real'(sample_addr);
        end
        if (training) begin
          trains++;
          check("settle_gap", cyc - last_load - 1, SETTLE);
        end
        if (layer_rst) begin
          rsts++;
          first_rst = cyc;
        end
        if (epoch_loss_valid) begin
          loss_pulses++;
          check("loss_value_x1000", $rtoi(epoch_loss * 1000.0 + 0.5), $rtoi(exp_loss * 1000.0 + 0.5));
        end
        if (done) begin
          seen_done = 1;
          check("run_len", cyc, exp_len);
          check("epoch_final", epoch_count, (total > 0) ? ne - 1 : 0);
        end
        if (!seen_done) @(negedge clk);
      end
    end

    last_len = seen_done ? cyc : 0;
    last_trains = trains;
    if (aborted) begin
      check("abort_trains", trains, abort_upd - 1);
      exp_q.delete();
    end else begin
      check("done_timeout", seen_done, 1);
      check("train_count", trains, total);
      check("load_count", loads, total);
      check("addr_seq_left", exp_q.size(), 0);
      check("layer_rst_count", rsts, (init && total > 0) ? 1 : 0);
      if (init && total > 0) check("layer_rst_cycle", first_rst, 1);
      if (total > 0) check("first_load_cycle", first_load, init ? 2 : 1);
`ifdef MLP_TRAIN_SCHED_LOSS_EN
      check("loss_pulses", loss_pulses, (total > 0) ? ne : 0);
`else
      check("loss_pulses", loss_pulses, 0);
      check("loss_held_zero", (epoch_loss == 0.0) ? 1 : 0, 1);
`endif
      @(negedge clk);
      check("idle_after_done", busy, 0);
      check("done_one_cycle", done, 0);
    end
  endtask

  initial begin
    vecs[0] = '{init: 1'b0, ns: 3,  ne: 2, exp_len: 31, exp_train: 6};
    vecs[1] = '{init: 1'b1, ns: 3,  ne: 2, exp_len: 32, exp_train: 6};
    vecs[2] = '{init: 1'b0, ns: 0,  ne: 5, exp_len: 1,  exp_train: 0};
    vecs[3] = '{init: 1'b1, ns: 4,  ne: 0, exp_len: 1,  exp_train: 0};
    vecs[4] = '{init: 1'b0, ns: 1,  ne: 1, exp_len: 6,  exp_train: 1};
    vecs[5] = '{init: 1'b0, ns: 2,  ne: 2, exp_len: 21, exp_train: 4};
    vecs[6] = '{init: 1'b1, ns: 2,  ne: 2, exp_len: 22, exp_train: 4};
    vecs[7] = '{init: 1'b0, ns: 16, ne: 1, exp_len: 81, exp_train: 16};

    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_training", training, 0);
    check("rst_load", load_sample, 0);
    check("rst_layer_rst", layer_rst, 0);
    check("rst_addr", sample_addr, 0);
    check("rst_epoch", epoch_count, 0);
    check("rst_loss_valid", epoch_loss_valid, 0);
    check("rst_loss_zero", (epoch_loss == 0.0) ? 1 : 0, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Abort and start together in IDLE: start wins.
    abort = 1'b1;
    start = 1'b1; init_weights = 1'b0; num_samples = 5'd1; num_epochs = 16'd1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check("start_beats_idle_abort", busy, 1);
    repeat (SETTLE + 3) @(negedge clk);
    check("short_run_done", done, 1);
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      do_run(vecs[i].init, vecs[i].ns, vecs[i].ne, 0);
      check("tbl_run_len", last_len, vecs[i].exp_len);
      check("tbl_trains", last_trains, vecs[i].exp_train);
    end

    // Abort at the second UPDATE, then restart in the very next (IDLE) cycle.
    do_run(1'b0, 3, 2, 2);
    do_run(1'b0, 2, 1, 0);

    for (int i = 0; i < 8; i++)
      do_run(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 3), 0);

    // Mid-run reset during SETTLE: outputs clear asynchronously and nothing resumes.
    start = 1'b1; init_weights = 1'b0; num_samples = 5'd3; num_epochs = 16'd2;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20 && !load_sample; k++) @(negedge clk);
    check("reset_seq_load_seen", load_sample, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_load", load_sample, 0);
    check("async_rst_training", training, 0);
    check("async_rst_layer_rst", layer_rst, 0);
    check("async_rst_done", done, 0);
    check("async_rst_addr", sample_addr, 0);
    check("async_rst_epoch", epoch_count, 0);
    check("async_rst_loss_valid", epoch_loss_valid, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    begin
      int strobes;
      strobes = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (training || load_sample || busy || done) strobes++;
      end
      check("post_reset_quiet", strobes, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mlp_train_scheduler.md
# mlp_train_scheduler

Sequencer that drives supervised training of the MLP layer array. It walks a sample memory for a programmed number of epochs. For each sample it latches inputs and targets into the layers, waits for the combinational forward/backward datapath to settle, and then issues exactly one `training` strobe so every perceptron applies its weight and bias update. It sits between the host/testbench control interface and the layer instances, which share its `training` and `layer_rst` outputs.

## Interface
- `ADDR_W`, default 4: sample-memory address width; up to 2^ADDR_W samples.
- `EPOCH_W`, default 16: epoch counter width.
- `SETTLE_CYCLES`, default 2: cycles between `load_sample` and `training`; legal range 1..15.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: start request; sampled only in IDLE.
- `init_weights` in 1: sampled with `start`; when 1, pulse `layer_rst` before training begins.
- `num_samples` in ADDR_W+1: samples per epoch; latched on accepted `start`.
- `num_epochs` in EPOCH_W: epoch count; latched on accepted `start`.
- `abort` in 1: terminate the run; highest priority.
- `sample_sq_error` in real: squared output error of the current sample; valid in the UPDATE cycle.
- `sample_addr` out ADDR_W: index of the current sample in the sample memory.
- `load_sample` out 1: one-cycle strobe to latch inputs and targets at `sample_addr`.
- `training` out 1: one-cycle weight-update enable to all layers.
- `layer_rst` out 1: one-cycle weight re-initialisation strobe to the layers (active-high).
- `busy` out 1: run in progress.
- `done` out 1: one-cycle completion pulse.
- `epoch_count` out EPOCH_W: index of the current epoch.
- `epoch_loss` out real: mean squared error of the last completed epoch.
- `epoch_loss_valid` out 1: one-cycle pulse when `epoch_loss` updates.

## Operation
- States: IDLE, INIT, LOAD, SETTLE, UPDATE, NEXT, DONE. All outputs are decoded from registered state and counters.
- IDLE:
  - On `start`, latch `num_samples` and `num_epochs`, and clear the sample index, epoch counter and settle counter.
  - If `num_samples`==0 or `num_epochs`==0, go to DONE; no `load_sample` or `training` is issued.
  - Otherwise, if `init_weights`=1, go to INIT; else go to LOAD.
- INIT: `layer_rst`=1 for one cycle, then go to LOAD.
- LOAD: `load_sample`=1, `sample_addr`=sample index, then go to SETTLE.
- SETTLE: hold for SETTLE_CYCLES cycles with `training`=0, then go to UPDATE.
- UPDATE: `training`=1 for one cycle, then go to NEXT.
- NEXT:
  - If the sample index is less than `num_samples`-1, increment it and go to LOAD.
  - Otherwise (epoch wrap), set the sample index to 0.
    - If `epoch_count`==`num_epochs`-1, go to DONE.
    - Else increment `epoch_count` and go to LOAD.
- DONE: `done`=1 for one cycle, then go to IDLE. `epoch_count` holds its final value until the next accepted `start`.
- `busy`=1 in every state except IDLE.
- `start` while busy is ignored. Latched parameters do not change mid-run.
- `abort`=1 in any non-IDLE state:
  - The next state is IDLE.
  - `training` and `layer_rst` are gated low in that same cycle.
  - `done` is not pulsed.
- `abort` in IDLE is ignored. `abort` and `start` together in IDLE: `start` is accepted.
- Reset mid-run returns to IDLE immediately. No further strobes are issued.

## Timing
- Reset values:
  - State IDLE.
  - `sample_addr`=0, `epoch_count`=0.
  - `load_sample`, `training`, `layer_rst`, `busy`, `done`, `epoch_loss_valid` all 0.
  - `epoch_loss`=0.0.
- `busy` rises the cycle after `start` is sampled.
- Per-sample period: SETTLE_CYCLES+3 cycles. There are exactly SETTLE_CYCLES cycles between the `load_sample` cycle and the `training` cycle, exclusive.
- Run length from the first busy cycle to the `done` cycle inclusive: (init ? 1 : 0) + N·E·(SETTLE_CYCLES+3) + 1.
- A zero-count run: `done` arrives 1 cycle after `start`, with `busy` high for that one cycle.
- `start` may be re-asserted in the cycle after `done` (IDLE).

## Configuration
- `MLP_TRAIN_SCHED_LOSS_EN` defined:
  - In each UPDATE cycle, add `sample_sq_error` to an accumulator.
  - In the NEXT cycle of an epoch wrap, set `epoch_loss` to accumulator/`num_samples`, pulse `epoch_loss_valid`, and clear the accumulator.
  - The accumulator clears on accepted `start` and on `abort`.
- Not defined: the ports remain, `epoch_loss` is held at 0.0, `epoch_loss_valid` is held at 0, and no accumulator is built.

## Test plan
- Basic run:
  - Stimulus: `num_samples`=3, `num_epochs`=2, SETTLE_CYCLES=2, `init_weights`=0.
  - Required: 6 `training` pulses; `sample_addr` sequence 0,1,2,0,1,2; `done` exactly 31 cycles after `busy` rises; `epoch_count` ends at 1.
- Init:
  - Stimulus: same as basic run with `init_weights`=1.
  - Required: one `layer_rst` in the first busy cycle; `load_sample` in the next cycle; total run is 32 cycles.
- Zero count:
  - Stimulus: `num_samples`=0, `num_epochs`=5.
  - Required: `done` the cycle after `start`; zero `load_sample` and zero `training` pulses.
- Abort:
  - Stimulus: assert `abort` in the 2nd UPDATE cycle.
  - Required: that cycle shows `training`=0; IDLE next cycle; no `done`; `start` accepted the following cycle.
- Loss (macro on):
  - Stimulus: `num_samples`=2, `sample_sq_error` 0.5 then 1.5.
  - Required: `epoch_loss`=1.0 with a single `epoch_loss_valid` pulse per epoch.
- Reset:
  - Stimulus: assert `rst`=0 during SETTLE.
  - Required: all outputs return to their reset values asynchronously; no `training` pulse after reset is released.
